// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-requester arbiter in front of a shared combinational ALU,
// one-cycle registered response. Define ALU_ARB_RR_EN for round-robin ties,
// otherwise requester 0 has fixed priority.                         Rev 1.0
// ============================================================================
`default_nettype none

module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_aluc,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_aluc,
  output logic        req1_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_aluc,
  input  logic [31:0] alu_out,
  input  logic        zero,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  input  logic        rsp_ready
);

  logic last_grant;
  logic slot_free;
  logic tie_to_1;
  logic grant0;
  logic grant1;
  logic transfer;

  assign slot_free = ~rsp_valid | rsp_ready;

`ifdef ALU_ARB_RR_EN
  // Round-robin: on a tie the requester that did not win last time goes.
  assign tie_to_1 = ~last_grant;
`else
  assign tie_to_1 = 1'b0;
`endif

  assign grant1   = slot_free & req1_valid & (~req0_valid | tie_to_1);
  assign grant0   = slot_free & req0_valid & ~grant1;
  assign transfer = grant0 | grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Requester 0 drives the ALU whenever requester 1 is not granted.
  assign alu_a    = grant1 ? req1_a    : req0_a;
  assign alu_b    = grant1 ? req1_b    : req0_b;
  assign alu_aluc = grant1 ? req1_aluc : req0_aluc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_zero   <= 1'b0;
      last_grant <= 1'b1;
    end else if (transfer) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant1;
      rsp_data   <= alu_out;
      rsp_zero   <= zero;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of the arbiter and response slot.
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_aluc, req1_aluc;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_aluc;
  logic        zero;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_ready;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  bit          m_valid;
  int          m_id;
  logic [31:0] m_data;
  bit          m_zero;
  int          m_last;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'b001:  return a - b;
      3'b010:  return a | b;
      3'b011:  return a & b;
      default: return a + b;
    endcase
  endfunction

  // Shared ALU lives in the environment
  assign alu_out = alu_fn(alu_a, alu_b, alu_aluc);
  assign zero    = (alu_out == 32'd0);

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_out(alu_out), .zero(zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_ready(rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = 0; m_zero = 0; m_last = 1;
  endtask

  task automatic chk_rsp(input string tag);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".rsp_id"},   32'(rsp_id),   32'(m_id));
      chk({tag, ".rsp_data"}, rsp_data,      m_data);
      chk({tag, ".rsp_zero"}, 32'(rsp_zero), 32'(m_zero));
    end
  endtask

  int last_winner;

  // One clock cycle: drive at negedge, check grant just before the edge,
  // check the registered response just after it.
  task automatic step(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                      input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                      input bit rr, input string tag);
    int w;
    bit free;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_aluc = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_aluc = c1;
    rsp_ready  = rr;
    #1;
    free = !m_valid || rr;
    w = -1;
    if (free) begin
      if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
        w = (m_last == 1) ? 0 : 1;
`else
        w = 0;
`endif
      end else if (v0) w = 0;
      else if (v1) w = 1;
    end
    chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(w == 0));
    chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(w == 1));
    chk({tag, ".alu_a"}, alu_a, (w == 1) ? a1 : a0);
    chk({tag, ".alu_aluc"}, 32'(alu_aluc), 32'((w == 1) ? c1 : c0));
    last_winner = w;
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_valid = 1;
      m_id    = w;
      m_data  = (w == 1) ? alu_fn(a1, b1, c1) : alu_fn(a0, b0, c0);
      m_zero  = (m_data == 32'd0);
      m_last  = w;
    end else if (rr) begin
      m_valid = 0;
    end
    chk_rsp(tag);
  endtask

  initial begin
    bit          v0, v1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  c0, c1;

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_aluc = 0;
    req1_a = 0; req1_b = 0; req1_aluc = 0;
    model_reset();
    #2;
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_data",  rsp_data, 32'd0);
    chk("reset.rsp_zero",  32'(rsp_zero), 32'd0);
    chk("reset.rsp_id",    32'(rsp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Subtract on requester 0: 5 - 3 = 2
    step(1, 32'd5, 32'd3, 3'b001, 0, 0, 0, 0, 1, "sub0");
    chk("sub0.data_const", rsp_data, 32'd2);
    // AND on requester 1 giving zero
    step(0, 0, 0, 0, 1, 32'hF0, 32'h0F, 3'b011, 1, "and1");
    chk("and1.zero_const", 32'(rsp_zero), 32'd1);

    // Four-cycle tie
    for (int i = 0; i < 4; i++)
      step(1, 32'd10 + 32'(i), 32'd1, 3'b000, 1, 32'd100, 32'(i), 3'b010, 1, $sformatf("tie%0d", i));

    // Backpressure: response held for three cycles, then accepted
    for (int i = 0; i < 3; i++)
      step(1, 32'd7, 32'd7, 3'b001, 1, 32'd8, 32'd9, 3'b000, 0, $sformatf("stall%0d", i));
    step(1, 32'd7, 32'd7, 3'b001, 1, 32'd8, 32'd9, 3'b000, 1, "release");
    chk("release.granted", 32'(last_winner >= 0), 32'd1);

    // Asynchronous reset while a response is pending
    step(1, 32'd1, 32'd2, 3'b010, 0, 0, 0, 0, 0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst.rsp_data",  rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'd3, 32'd4, 3'b000, 1, 32'd5, 32'd6, 3'b000, 1, "post_rst");
    chk("post_rst.id_const", 32'(rsp_id), 32'd0);

    // Wrap-around add via an undefined op code
    step(1, 32'hFFFF_FFFF, 32'd1, 3'b111, 0, 0, 0, 0, 1, "wrap");
    chk("wrap.data_const", rsp_data, 32'd0);

    // Randomized traffic; a waiting requester keeps its operation stable
    v0 = 0; v1 = 0;
    a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
    for (int i = 0; i < 300; i++) begin
      bit hold0, hold1;
      hold0 = v0 && (last_winner != 0);
      hold1 = v1 && (last_winner != 1);
      if (!hold0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        c0 = 3'($urandom_range(0, 7));
      end
      if (!hold1) begin
        v1 = ($urandom_range(0, 3) != 0);
        a1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        c1 = 3'($urandom_range(0, 7));
      end
      step(v0, a0, b0, c0, v1, a1, b1, c1, bit'($urandom_range(0, 2) != 0), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0 (pipeline EX) / requester 1 (secondary: branch/address unit) has an operation.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-006 req0_aluc, req1_aluc  input  3 each  op code: 000 add, 001 sub, 010 or, 011 and, others add.
REQ-007 req0_ready / req1_ready  output  1 each  grant; transfer occurs when valid and ready are both high at a rising edge.
REQ-008 alu_a, alu_b  output  32 each, alu_aluc  output  3  drive the shared ALU.
REQ-009 alu_out  input  32, zero  input  1  combinational ALU result and zero flag.
REQ-010 rsp_valid  output  1, rsp_id  output  1, rsp_data  output  32, rsp_zero  output  1  registered result, owner ID, value and zero flag.
REQ-011 rsp_ready  input  1  consumer accepts the response.

Function
REQ-012 Response slot free (slot_free) SHALL equal !rsp_valid | rsp_ready.
REQ-013 With slot_free low, req0_ready and req1_ready SHALL both be 0.
REQ-014 With slot_free high, at most one readyN SHALL be 1, and only for a requester with validN high; ready is combinational from valid, slot_free and the arbitration state.
REQ-015 alu_a/alu_b/alu_aluc SHALL carry the granted requester's operands and op; with no grant they SHALL carry requester 0's fields.
REQ-016 On a transfer, the next edge SHALL load rsp_data=alu_out, rsp_zero=zero, rsp_id=granted index, rsp_valid=1: latency exactly one cycle.
REQ-017 With no transfer and rsp_ready high, the next edge SHALL clear rsp_valid.
REQ-018 While rsp_valid & !rsp_ready, rsp_data/rsp_zero/rsp_id SHALL hold.
REQ-019 Back-to-back transfers SHALL sustain one operation per cycle when rsp_ready stays high.
REQ-020 Requesters SHALL hold operands stable while valid & !ready; the block SHALL NOT buffer requests.
REQ-021 A 1-bit last_grant register SHALL record the index of the most recent transfer.
REQ-022 Simultaneous valid with slot free: the winner SHALL follow REQ-027/REQ-028.
REQ-023 Single valid with slot free: that requester SHALL be granted regardless of last_grant.

Reset
REQ-024 While rst_n is low: rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0, last_grant=1. Outputs reach these values without a clock edge.
REQ-025 Reset asserted mid-operation SHALL discard any pending response; the first grant after release SHALL follow the REQ-024 reset state.

Configuration
REQ-026 The macro ALU_ARB_RR_EN SHALL select the arbitration policy.
REQ-027 With ALU_ARB_RR_EN defined: round-robin. On a tie the requester other than last_grant wins. From reset (last_grant=1), requester 0 wins the first tie.
REQ-028 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins a tie. last_grant is still maintained.

Verification
REQ-029 Reset, then req0 a=5 b=3 aluc=001, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=2, rsp_zero=0.
REQ-030 req1 a=0xF0 b=0x0F aluc=011 alone -> rsp_data=0, rsp_zero=1, rsp_id=1.
REQ-031 Both valid for 4 cycles, rsp_ready=1, RR build -> grants 0,1,0,1. Fixed build -> grants 0,0,0,0 with req1_ready=0 throughout.
REQ-032 rsp_valid=1, rsp_ready=0 for 3 cycles with both requests valid -> both readies 0 and the rsp fields hold. Raise rsp_ready -> a grant occurs in that same cycle.
REQ-033 Assert rst_n=0 mid-cycle while rsp_valid=1 -> rsp_valid=0 immediately. After release, with both valid, requester 0 is granted first.
REQ-034 aluc=111, a=0xFFFFFFFF, b=1 -> rsp_data=0, rsp_zero=1 (wrap-around add).
